ntt_ctrl: RTL and testbench

- Sequencer for the in-place, iterative Kyber NTT over a 256-coefficient polynomial RAM, driving a single shared butterfly unit.
- Generates dual-port RAM read addresses, zeta-ROM index (128-entry table), butterfly valid and delayed write-back addresses.
- Walks 7 layers × 128 butterflies per transform.
- Sits between the top-level polynomial engine (start/done) and the RAM + zeta ROM + butterfly datapath.

---
 rtl/ntt_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ntt_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address and control sequencer for an in-place iterative Kyber NTT.
// Walks 7 layers x 128 butterflies over a 256-entry coefficient RAM. It issues
// dual-port read addresses and a zeta-ROM index, then delays the read strobe
// to form the butterfly valid and the write-back enable and addresses.
//
// Optional feature macro: NTT_INVERSE_EN
//   Adds the inv_i and bf_gs_o ports and the Gentleman-Sande (inverse) ordering.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin a transform (sampled only while idle)
//   inv_i           inverse order select, sampled with start_i (NTT_INVERSE_EN only)
//   bf_gs_o         latched inverse select, low while idle (NTT_INVERSE_EN only)
//   busy_o          transform in progress (issue and drain phases)
//   done_o          one-cycle pulse after the final write-back
//   layer_o         current layer 0..6
//   rd_en_o         butterfly read issued this cycle
//   rd_addr_a_o/b_o read addresses j and j+len
//   zeta_idx_o      zeta ROM index, aligned with rd_en_o
//   bf_valid_o      rd_en_o delayed by RD_LAT
//   wr_en_o         rd_en_o delayed by RD_LAT+BF_LAT
//   wr_addr_a_o/b_o read addresses delayed by RD_LAT+BF_LAT
module ntt_ctrl #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
`ifdef NTT_INVERSE_EN
    input  logic       inv_i,
    output logic       bf_gs_o,
`endif
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] layer_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [6:0] zeta_idx_o,
    output logic       bf_valid_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    localparam int unsigned Lat       = RD_LAT + BF_LAT;
    localparam logic [3:0]  DrainLast = 4'(Lat - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] bfly_q, bfly_d;
    logic [3:0] drain_q, drain_d;
    logic       inverse;

`ifdef NTT_INVERSE_EN
    logic inv_q;

    // Direction is captured on the accepting edge and held for the whole transform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state_q == StIdle) begin
            inv_q <= start_i & inv_i;
        end
    end

    assign inverse = inv_q;
    assign bf_gs_o = inv_q & (state_q != StIdle);
`else
    assign inverse = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        bfly_d  = bfly_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StIssue;
                    layer_d = 3'd0;
                    bfly_d  = 7'd0;
                end
            end
            StIssue: begin
                bfly_d = bfly_q + 7'd1;
                if (bfly_q == 7'd127) begin
                    state_d = StDrain;
                    drain_d = 4'd0;
                end
            end
            StDrain: begin
                // Wait out the read + butterfly pipeline so every write of this
                // layer lands before the next layer reads.
                drain_d = drain_q + 4'd1;
                if (drain_q == DrainLast) begin
                    drain_d = 4'd0;
                    if (layer_q == 3'd6) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        layer_d = layer_q + 3'd1;
                        bfly_d  = 7'd0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                layer_d = 3'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            layer_q <= 3'd0;
            bfly_q  <= 7'd0;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            bfly_q  <= bfly_d;
            drain_q <= drain_d;
        end
    end

    // Address generation. With len = 1 << shamt, j is b with a zero bit inserted
    // at position shamt, i.e. g*2*len + off; the b partner sets that bit (j+len).
    logic [2:0] shamt;
    logic [7:0] b_ext, len, mask, j;
    logic [6:0] grp, zeta;

    assign shamt = inverse ? (layer_q + 3'd1) : (3'd7 - layer_q);
    assign b_ext = {1'b0, bfly_q};
    assign len   = 8'd1 << shamt;
    assign mask  = len - 8'd1;
    assign j     = ((b_ext & ~mask) << 1) | (b_ext & mask);
    assign grp   = bfly_q >> shamt;
    // Forward walks zetas upward from 1<<l; inverse walks down from (128>>l)-1.
    assign zeta  = inverse ? ((7'd127 >> layer_q) - grp) : ((7'd1 << layer_q) + grp);

    assign rd_en_o     = (state_q == StIssue);
    assign rd_addr_a_o = rd_en_o ? j : 8'd0;
    assign rd_addr_b_o = rd_en_o ? (j | len) : 8'd0;
    assign zeta_idx_o  = rd_en_o ? zeta : 7'd0;
    assign busy_o      = (state_q == StIssue) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);
    assign layer_o     = layer_q;

    // Delay line for the read strobe and addresses; runs freely through drain.
    logic [Lat-1:0] vld_q;
    logic [7:0]     wa_q [Lat];
    logic [7:0]     wb_q [Lat];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(Lat); i++) begin
                wa_q[i] <= 8'd0;
                wb_q[i] <= 8'd0;
            end
        end else begin
            vld_q   <= {vld_q[Lat-2:0], rd_en_o};
            wa_q[0] <= rd_addr_a_o;
            wb_q[0] <= rd_addr_b_o;
            for (int i = 1; i < int'(Lat); i++) begin
                wa_q[i] <= wa_q[i-1];
                wb_q[i] <= wb_q[i-1];
            end
        end
    end

    assign bf_valid_o  = vld_q[RD_LAT-1];
    assign wr_en_o     = vld_q[Lat-1];
    assign wr_addr_a_o = wa_q[Lat-1];
    assign wr_addr_b_o = wb_q[Lat-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
module tb_ntt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
`ifdef NTT_INVERSE_EN
    logic       inv = 1'b0;
    logic       bf_gs;
`endif
    logic       busy, done, rd_en, bf_valid, wr_en;
    logic [2:0] layer;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] zeta_idx;

    always #5 clk = ~clk;

    ntt_ctrl #(.RD_LAT(1), .BF_LAT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
`ifdef NTT_INVERSE_EN
        .inv_i      (inv),
        .bf_gs_o    (bf_gs),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .layer_o    (layer),
        .rd_en_o    (rd_en),
        .rd_addr_a_o(rd_addr_a),
        .rd_addr_b_o(rd_addr_b),
        .zeta_idx_o (zeta_idx),
        .bf_valid_o (bf_valid),
        .wr_en_o    (wr_en),
        .wr_addr_a_o(wr_addr_a),
        .wr_addr_b_o(wr_addr_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon = 1'b0;

    int exp_a [896];
    int exp_b [896];
    int exp_z [896];
    int exp_l [896];
    int cov [8][256];
    int ei, rd_cnt, wr_cnt, seq_err, wr_err, done_cnt, done_cyc, stray;
    logic done_busy;
    logic       h_en [8];
    logic [7:0] h_a [8];
    logic [7:0] h_b [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference ordering taken from the textbook Kyber NTT / inverse NTT loops.
    task automatic build_model(input bit inv_b);
        int n = 0;
        int k = inv_b ? 127 : 1;
        int lay = 0;
        for (int len = (inv_b ? 2 : 128); len >= 2 && len <= 128;
             len = (inv_b ? len * 2 : len / 2)) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    exp_a[n] = j;
                    exp_b[n] = j + len;
                    exp_z[n] = k;
                    exp_l[n] = lay;
                    n++;
                end
                k = inv_b ? k - 1 : k + 1;
            end
            lay++;
        end
    endtask

    // One clock; afterwards cyc names the cycle now being observed.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon) begin
            if (rd_en === 1'b1) begin
                rd_cnt++;
                if (ei < 896) begin
                    if (rd_addr_a !== 8'(exp_a[ei]) || rd_addr_b !== 8'(exp_b[ei]) ||
                        zeta_idx !== 7'(exp_z[ei]) || layer !== 3'(exp_l[ei]))
                        seq_err++;
                end else begin
                    seq_err++;
                end
                ei++;
                cov[layer][rd_addr_a]++;
                cov[layer][rd_addr_b]++;
            end
            if (wr_en === 1'b1) wr_cnt++;
            if (wr_en !== h_en[(cyc + 4) % 8]) wr_err++;
            else if (wr_en && (wr_addr_a !== h_a[(cyc + 4) % 8] ||
                               wr_addr_b !== h_b[(cyc + 4) % 8])) wr_err++;
            if (bf_valid !== h_en[(cyc + 7) % 8]) wr_err++;
            h_en[cyc % 8] = rd_en;
            h_a[cyc % 8]  = rd_addr_a;
            h_b[cyc % 8]  = rd_addr_b;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic begin_run(input bit inv_b);
        build_model(inv_b);
        ei = 0; rd_cnt = 0; wr_cnt = 0; seq_err = 0; wr_err = 0;
        done_cnt = 0; done_cyc = 0; done_busy = 1'b0;
        for (int l = 0; l < 8; l++)
            for (int a = 0; a < 256; a++) cov[l][a] = 0;
        for (int i = 0; i < 8; i++) begin
            h_en[i] = 1'b0; h_a[i] = 8'd0; h_b[i] = 8'd0;
        end
        mon = 1'b1;
        cyc = 0;
        start = 1'b1;
`ifdef NTT_INVERSE_EN
        inv = inv_b;
`endif
        tick();
        start = 1'b0;
`ifdef NTT_INVERSE_EN
        inv = 1'b0;
`endif
    endtask

    task automatic end_run(input string tag);
        int cov_err = 0;
        tick_to(940);
        mon = 1'b0;
        for (int l = 0; l < 8; l++)
            for (int a = 0; a < 256; a++)
                if (cov[l][a] != ((l < 7) ? 1 : 0)) cov_err++;
        chk({tag, ".rd_count"}, rd_cnt, 896);
        chk({tag, ".wr_count"}, wr_cnt, 896);
        chk({tag, ".rd_order"}, seq_err, 0);
        chk({tag, ".wr_delay"}, wr_err, 0);
        chk({tag, ".coverage"}, cov_err, 0);
        chk({tag, ".done_count"}, done_cnt, 1);
        chk({tag, ".done_cycle"}, done_cyc, 925);
        chk({tag, ".busy_at_done"}, done_busy, 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("reset.outputs", {busy, done, layer, rd_en, rd_addr_a, rd_addr_b, zeta_idx,
                              bf_valid, wr_en, wr_addr_a, wr_addr_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle.busy", busy, 0);
        chk("idle.rd_en", rd_en, 0);

        // Forward run with directed spot checks
        begin_run(1'b0);
        chk("c1.rd_en", rd_en, 1);
        chk("c1.addr_a", rd_addr_a, 0);
        chk("c1.addr_b", rd_addr_b, 128);
        chk("c1.zeta", zeta_idx, 1);
        chk("c1.layer", layer, 0);
        chk("c1.busy", busy, 1);
        chk("c1.bf_valid", bf_valid, 0);
        tick_to(2);
        chk("c2.bf_valid", bf_valid, 1);
        tick_to(5);
        chk("c5.wr_en", wr_en, 1);
        chk("c5.wr_addr_a", wr_addr_a, 0);
        chk("c5.wr_addr_b", wr_addr_b, 128);
        tick_to(128);
        chk("c128.addr_a", rd_addr_a, 127);
        chk("c128.addr_b", rd_addr_b, 255);
        chk("c128.zeta", zeta_idx, 1);
        tick_to(129);
        chk("c129.drain_rd_en", rd_en, 0);
        chk("c129.drain_busy", busy, 1);
        tick_to(197);
        chk("l1b64.layer", layer, 1);
        chk("l1b64.addr_a", rd_addr_a, 128);
        chk("l1b64.addr_b", rd_addr_b, 192);
        chk("l1b64.zeta", zeta_idx, 3);
        tick_to(920);
        chk("l6b127.layer", layer, 6);
        chk("l6b127.addr_a", rd_addr_a, 253);
        chk("l6b127.addr_b", rd_addr_b, 255);
        chk("l6b127.zeta", zeta_idx, 127);
        tick_to(924);
        chk("c924.wr_en", wr_en, 1);
        chk("c924.wr_addr_a", wr_addr_a, 253);
        chk("c924.wr_addr_b", wr_addr_b, 255);
        tick_to(925);
        chk("c925.done", done, 1);
        chk("c925.wr_en", wr_en, 0);
        tick_to(926);
        chk("c926.done", done, 0);
        chk("c926.layer", layer, 0);
        end_run("fwd");

        // start re-pulsed while busy is ignored
        begin_run(1'b0);
        tick_to(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        end_run("repulse");

        // Reset mid-transform
        begin_run(1'b0);
        tick_to(300);
        chk("c300.busy", busy, 1);
        mon = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort.outputs", {busy, done, layer, rd_en, rd_addr_a, rd_addr_b, zeta_idx,
                              bf_valid, wr_en, wr_addr_a, wr_addr_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) stray++;
        end
        chk("abort.no_activity", stray, 0);
        begin_run(1'b0);
        end_run("after_abort");

`ifdef NTT_INVERSE_EN
        // Inverse (Gentleman-Sande) order
        begin_run(1'b1);
        chk("inv.c1.bf_gs", bf_gs, 1);
        chk("inv.c1.addr_a", rd_addr_a, 0);
        chk("inv.c1.addr_b", rd_addr_b, 2);
        chk("inv.c1.zeta", zeta_idx, 127);
        tick_to(2);
        chk("inv.b1.addr_a", rd_addr_a, 1);
        chk("inv.b1.zeta", zeta_idx, 127);
        tick_to(3);
        chk("inv.b2.addr_a", rd_addr_a, 4);
        chk("inv.b2.addr_b", rd_addr_b, 6);
        chk("inv.b2.zeta", zeta_idx, 126);
        tick_to(793);
        chk("inv.l6b0.layer", layer, 6);
        chk("inv.l6b0.addr_a", rd_addr_a, 0);
        chk("inv.l6b0.addr_b", rd_addr_b, 128);
        chk("inv.l6b0.zeta", zeta_idx, 1);
        chk("inv.l6b0.bf_gs", bf_gs, 1);
        end_run("inv");
        chk("inv.idle_bf_gs", bf_gs, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
